// File: rtl/iq_avg_snap_ctrl.sv
// iq_avg_snap_ctrl: sequences IQ frame accumulation, the accumulator dump
// and the snapshot capture of averaged words, with status for software.
module iq_avg_snap_ctrl #(
    parameter int N_CHAN = 256,
    parameter int ADDR_W = 8
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_word_i,
    input  logic              iq_valid_i,
    input  logic              iq_last_i,
    input  logic              avg_valid_i,
    input  logic              avg_last_i,
    output logic              acc_clear_o,
    output logic              acc_en_o,
    output logic              acc_dump_o,
    output logic              snap_we_o,
    output logic [ADDR_W-1:0] snap_addr_o,
    output logic [31:0]       status_word_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        ACCUM   = 3'd2,
        DUMP    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              start_prev_q;
    logic [15:0]       nfm1_q, nfm1_d;
    logic [16:0]       frame_q, frame_d;
    logic              done_q, done_d, aborted_q, aborted_d, clr_q, clr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start, abort, iq_end, last_addr, busy, unused_ctrl;

    assign start       = ctrl_word_i[0] && !start_prev_q;
    assign abort       = ctrl_word_i[1];
    assign iq_end      = iq_valid_i && iq_last_i;
    assign last_addr   = addr_q == ADDR_W'(N_CHAN - 1);
    assign busy        = state_q != IDLE;
    assign unused_ctrl = ^{ctrl_word_i[31:24], ctrl_word_i[7:2]};
    assign snap_addr_o = addr_q;
    assign status_word_o = {frame_q[16] ? 16'hFFFF : frame_q[15:0], 9'd0, state_q,
                            1'b0, aborted_q, done_q, busy};

    always_comb begin
        state_d     = state_q;
        nfm1_d      = nfm1_q;
        frame_d     = frame_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        clr_d       = 1'b0;
        addr_d      = addr_q;
        acc_clear_o = 1'b0;
        acc_en_o    = 1'b0;
        acc_dump_o  = 1'b0;
        snap_we_o   = 1'b0;
        // abort overrides everything, including the strobes of this cycle
        if (busy && abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (start && !abort) begin
                    state_d   = ARM;
                    nfm1_d    = ctrl_word_i[23:8];
                    frame_d   = '0;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    clr_d     = 1'b1;
                end
                ARM: begin
                    acc_clear_o = clr_q;
                    if (iq_end) state_d = ACCUM;
                end
                ACCUM: begin
                    acc_en_o = iq_valid_i;
                    if (iq_end) begin
                        frame_d = frame_q + 17'd1;
                        if (frame_q == {1'b0, nfm1_q}) state_d = DUMP;
                    end
                end
                DUMP: begin
                    acc_dump_o = 1'b1;
                    addr_d     = '0;
                    state_d    = CAPTURE;
                end
                CAPTURE: begin
                    snap_we_o = avg_valid_i;
                    if (avg_valid_i) begin
                        addr_d = addr_q + 1'b1;
                        if (avg_last_i || last_addr) state_d = DONE;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b1;
            nfm1_q       <= '0;
            frame_q      <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            clr_q        <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= ctrl_word_i[0];
            nfm1_q       <= nfm1_d;
            frame_q      <= frame_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            clr_q        <= clr_d;
            addr_q       <= addr_d;
        end
    end
endmodule
